// File: rtl/short_preamble_inserter.sv
// Prepends NUM_REPS repetitions of a programmable SYMBOL_LEN-sample short symbol
// to each AXI-Stream sample burst, then passes the payload through untouched.
module short_preamble_inserter #(
    parameter int WIDTH      = 32,
    parameter int SYMBOL_LEN = 16,
    parameter int NUM_REPS   = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [$clog2(SYMBOL_LEN)-1:0] i_tbl_addr,
    input  logic [WIDTH-1:0]              i_tbl_data,
    input  logic                          i_tbl_we,
    input  logic [WIDTH-1:0]              i_samples_tdata,
    input  logic                          i_samples_tlast,
    input  logic                          i_samples_tvalid,
    output logic                          i_samples_tready,
    output logic [WIDTH-1:0]              o_samples_tdata,
    output logic                          o_samples_tlast,
    output logic                          o_samples_tvalid,
    input  logic                          o_samples_tready,
    output logic                          o_active
);
    localparam int AW = $clog2(SYMBOL_LEN);
    localparam int RW = (NUM_REPS > 1) ? $clog2(NUM_REPS) : 1;

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD} state_t;

    state_t            state;
    logic [AW-1:0]     sample_idx;
    logic [RW-1:0]     rep_cnt;
    logic [WIDTH-1:0]  tbl [SYMBOL_LEN];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sample_idx <= '0;
            rep_cnt    <= '0;
            for (int i = 0; i < SYMBOL_LEN; i++) tbl[i] <= '0;
        end else begin
            // Table is only writable between bursts, including the exit cycle.
            if (state == IDLE && i_tbl_we) tbl[i_tbl_addr] <= i_tbl_data;

            case (state)
                IDLE: begin
                    if (i_samples_tvalid) begin
                        state      <= PREAMBLE;
                        sample_idx <= '0;
                        rep_cnt    <= '0;
                    end
                end
                PREAMBLE: begin
                    if (o_samples_tready) begin
                        sample_idx <= sample_idx + 1'b1;
                        if (sample_idx == AW'(SYMBOL_LEN - 1)) begin
                            rep_cnt <= rep_cnt + 1'b1;
                            if (rep_cnt == RW'(NUM_REPS - 1)) begin
                                state   <= PAYLOAD;
                                rep_cnt <= '0;
                            end
                        end
                    end
                end
                PAYLOAD: begin
                    if (i_samples_tvalid && o_samples_tready && i_samples_tlast) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Payload is a zero-latency passthrough, so the output mux is combinational.
    always_comb begin
        o_samples_tdata  = '0;
        o_samples_tlast  = 1'b0;
        o_samples_tvalid = 1'b0;
        i_samples_tready = 1'b0;
        o_active         = (state != IDLE);
        case (state)
            PREAMBLE: begin
                o_samples_tvalid = 1'b1;
                o_samples_tdata  = tbl[sample_idx];
            end
            PAYLOAD: begin
                o_samples_tvalid = i_samples_tvalid;
                o_samples_tdata  = i_samples_tdata;
                o_samples_tlast  = i_samples_tlast;
                i_samples_tready = o_samples_tready;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_short_preamble_inserter.sv
// Randomized bench for short_preamble_inserter: expected output stream is built
// from a model symbol table (preamble) followed by the driven payload.
module tb_short_preamble_inserter;
    localparam int WIDTH = 32, SL = 16, NR = 10, NPRE = SL * NR;

    logic             clk = 0, reset = 1;
    logic [3:0]       tbl_addr = '0;
    logic [WIDTH-1:0] tbl_data = '0;
    logic             tbl_we = 0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 0, in_valid = 0, in_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_last, o_valid, o_ready = 0, active;

    short_preamble_inserter #(.WIDTH(WIDTH), .SYMBOL_LEN(SL), .NUM_REPS(NR)) dut (
        .clk(clk), .reset(reset),
        .i_tbl_addr(tbl_addr), .i_tbl_data(tbl_data), .i_tbl_we(tbl_we),
        .i_samples_tdata(in_data), .i_samples_tlast(in_last),
        .i_samples_tvalid(in_valid), .i_samples_tready(in_ready),
        .o_samples_tdata(o_data), .o_samples_tlast(o_last),
        .o_samples_tvalid(o_valid), .o_samples_tready(o_ready),
        .o_active(active)
    );

    always #5 clk = ~clk;

    typedef struct { logic [WIDTH-1:0] d; logic l; } exp_t;
    exp_t             exp_q [$];
    logic [WIDTH-1:0] mtbl [SL];
    int               n_chk = 0, n_fail = 0;
    int               burst_out = 0, rdy_mode = 0;
    bit               mon_en = 0, prev_stall = 0;
    logic [WIDTH-1:0] prev_data;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Downstream ready: 0 = always ready, 1 = random 50%, else stalled.
    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0:       o_ready = 1'b1;
            1:       o_ready = 1'($urandom_range(0, 1));
            default: o_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (in_valid && in_ready) chk("in_before_preamble", 64'(burst_out >= NPRE), 1);
            if (prev_stall) begin
                chk("stall_valid", o_valid, 1);
                chk("stall_data", o_data, prev_data);
            end
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", o_data, e.d);
                    chk("out_last", o_last, e.l);
                end
                burst_out = o_last ? 0 : burst_out + 1;
            end
            prev_stall = o_valid && !o_ready;
            prev_data  = o_data;
        end
    end

    task automatic push_model(input logic [WIDTH-1:0] pl [$]);
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < SL; k++) exp_q.push_back('{mtbl[k], 1'b0});
        foreach (pl[i]) exp_q.push_back('{pl[i], 1'(i == pl.size() - 1)});
    endtask

    // Presents payload samples; lat is cycles from tvalid rise to first handshake.
    task automatic drive(input logic [WIDTH-1:0] pl [$], input bit hold,
                         output int lat, output logic v0, output logic v1);
        int cyc = 0;
        bit to = 0;
        lat = -1; v0 = 1'bx; v1 = 1'bx;
        for (int i = 0; i < pl.size() && !to; i++) begin
            bit fired = 0;
            in_data = pl[i]; in_last = (i == pl.size() - 1); in_valid = 1;
            while (!fired && !to) begin
                @(negedge clk);
                fired = in_ready;
                cyc++;
                if (cyc == 1) v0 = o_valid;
                if (cyc == 2) v1 = o_valid;
                @(posedge clk); #1;
                if (cyc > 5000) begin chk("drive_timeout", 64'(cyc), 0); to = 1; end
            end
            if (i == 0) lat = cyc - 1;
        end
        if (!hold) begin in_valid = 0; in_last = 0; end
    endtask

    task automatic tbl_write(input int a, input logic [WIDTH-1:0] d, input bit upd);
        tbl_addr = 4'(a); tbl_data = d; tbl_we = 1;
        @(posedge clk); #1;
        tbl_we = 0;
        if (upd) mtbl[a] = d;
    endtask

    initial begin
        logic [WIDTH-1:0] pl [$];
        int lat;
        logic v0, v1;
        foreach (mtbl[k]) mtbl[k] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_active", active, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_last", o_last, 0);
        @(posedge clk); #1;
        reset = 0; mon_en = 1;

        for (int k = 0; k < SL; k++) tbl_write(k, {16'(k), 16'(16'hFFFF - k)}, 1);

        // Single burst with latency check, always ready.
        pl = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        push_model(pl);
        drive(pl, 0, lat, v0, v1);
        chk("lat_t0_valid", v0, 0);
        chk("lat_t1_valid", v1, 1);
        chk("lat_first_payload", 64'(lat), 161);
        @(negedge clk);
        chk("idle_after_burst", active, 0);

        // Backpressure: same burst, then a random one.
        rdy_mode = 1;
        push_model(pl);
        drive(pl, 0, lat, v0, v1);
        pl = {};
        repeat (7) pl.push_back($urandom);
        push_model(pl);
        drive(pl, 0, lat, v0, v1);

        // Write during the preamble is ignored.
        pl = '{$urandom, $urandom};
        push_model(pl);
        fork
            drive(pl, 0, lat, v0, v1);
            begin
                int w = 0;
                do begin @(negedge clk); w++; end while (burst_out < 20 && w < 5000);
                @(posedge clk); #1;
                tbl_write(0, 32'hDEADBEEF, 0);
            end
        join
        repeat (2) @(posedge clk); #1;

        // Same write in IDLE takes effect.
        tbl_write(0, 32'hDEADBEEF, 1);
        pl = '{$urandom};
        push_model(pl);
        drive(pl, 0, lat, v0, v1);

        // Back-to-back single-sample bursts with valid held.
        rdy_mode = 0;
        @(posedge clk); #1;
        push_model('{32'h11});
        push_model('{32'h22});
        drive('{32'h11}, 1, lat, v0, v1);
        in_data = 32'h22; in_last = 1;
        @(negedge clk);
        chk("b2b_idle_active", active, 0);
        chk("b2b_idle_valid", o_valid, 0);
        @(negedge clk);
        chk("b2b_restart_active", active, 1);
        @(posedge clk); #1;
        drive('{32'h22}, 0, lat, v0, v1);
        @(negedge clk);
        chk("b2b_end_active", active, 0);

        // Reset mid-preamble.
        @(posedge clk); #1;
        push_model('{32'hB0});
        in_data = 32'hB0; in_last = 1; in_valid = 1;
        begin
            int w = 0;
            do begin @(negedge clk); w++; end while (burst_out < 50 && w < 5000);
            chk("reach_out50", 64'(burst_out >= 50), 1);
        end
        @(posedge clk); #1;
        reset = 1; mon_en = 0;
        @(posedge clk); #1;
        reset = 0; in_valid = 0; in_last = 0;
        exp_q.delete(); burst_out = 0; prev_stall = 0;
        mon_en = 1;
        @(negedge clk);
        chk("post_rst_valid", o_valid, 0);
        chk("post_rst_active", active, 0);
        foreach (mtbl[k]) mtbl[k] = '0;
        @(posedge clk); #1;
        rdy_mode = 1;
        pl = '{$urandom, $urandom, $urandom};
        push_model(pl);
        drive(pl, 0, lat, v0, v1);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("exp_queue_drained", 64'(exp_q.size()), 0);
        chk("final_idle", active, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/short_preamble_inserter.md
Name: short_preamble_inserter

Overview:
Transmit-side counterpart of the short preamble detection path. It prepends a programmable short training field (STF) to each outgoing sample burst. The STF is NUM_REPS repetitions of a SYMBOL_LEN-sample symbol held in an internal table. The block sits between the baseband sample source and the DAC/upconversion chain and passes payload samples through unmodified after the preamble.

Parameters:
WIDTH, 32, sample width; native packing {I[31:16], Q[15:0]}.
SYMBOL_LEN, 16, samples per short symbol; power of two, at least 2.
NUM_REPS, 10, symbol repetitions per preamble; at least 1.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
i_tbl_addr  input  $clog2(SYMBOL_LEN)  symbol table write address
i_tbl_data  input  WIDTH  symbol table write data
i_tbl_we  input  1  symbol table write enable
i_samples_tdata  input  WIDTH  payload samples
i_samples_tlast  input  1  last payload sample of burst
i_samples_tvalid  input  1  AXI-Stream valid
i_samples_tready  output  1  AXI-Stream ready
o_samples_tdata  output  WIDTH  preamble then payload samples
o_samples_tlast  output  1  last sample of burst
o_samples_tvalid  output  1  AXI-Stream valid
o_samples_tready  input  1  AXI-Stream ready
o_active  output  1  high while in PREAMBLE or PAYLOAD

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - State: IDLE.
  - sample_idx and rep_cnt: 0.
  - All table entries: 0.
  - i_samples_tready, o_samples_tvalid, o_samples_tlast, o_active: 0.
- Symbol table: SYMBOL_LEN x WIDTH registers with a combinational read port.
  - A write is accepted only in IDLE, with i_tbl_we=1 at the clock edge.
  - Writes in any other state are ignored.
  - A write in the same cycle IDLE exits still takes effect.
- State IDLE:
  - i_samples_tready=0 and o_samples_tvalid=0; the input sample is held, not consumed.
  - If i_samples_tvalid=1 at a clock edge, go to PREAMBLE with sample_idx=0 and rep_cnt=0.
  - The first preamble sample is presented on the following cycle, so latency from i_samples_tvalid to o_samples_tvalid is 1 cycle.
- State PREAMBLE:
  - Outputs: o_samples_tvalid=1, o_samples_tdata=table[sample_idx], o_samples_tlast=0, i_samples_tready=0.
  - On each output transfer (tvalid & tready), sample_idx increments and wraps at SYMBOL_LEN.
  - On wrap, rep_cnt increments.
  - After the transfer with sample_idx=SYMBOL_LEN-1 and rep_cnt=NUM_REPS-1, go to PAYLOAD.
  - Exactly NUM_REPS*SYMBOL_LEN preamble samples are emitted per burst.
  - o_samples_tdata is stable while tvalid=1 and tready=0.
- State PAYLOAD: combinational passthrough.
  - o_samples_tdata/tlast/tvalid = i_samples_*.
  - i_samples_tready = o_samples_tready.
  - On a transfer with i_samples_tlast=1, go to IDLE.
  - There is no gap between the last preamble sample and the first payload sample when both sides are ready.
- Back-to-back bursts:
  - After returning to IDLE, the next burst starts another full preamble.
  - There is a minimum of one idle cycle between bursts.
- Single-sample burst (tlast on the first payload sample): full preamble, then 1 payload sample with tlast=1, then IDLE.
- Reset mid-burst:
  - Returns to IDLE immediately and clears the table.
  - Any partially sent preamble or payload is abandoned; there is no tlast flush.
- o_active=1 in PREAMBLE and PAYLOAD, 0 in IDLE.
- No arithmetic on sample data; payload bits pass through unmodified.

Test Plan:
- Table programming and single burst: write table[k]={k,16'hFFFF-k}, k=0..15; send a 4-sample burst 0xA0..0xA3 with tlast on 0xA3. Expect 160 outputs equal to the table pattern repeated 10 times, then 0xA0..0xA3 with tlast only on 0xA3, then o_active=0.
- Backpressure: same stimulus with o_samples_tready randomly 50% low. Expect an identical output sequence, tdata stable while stalled, and no input consumed before output 160.
- Write lockout: while in PREAMBLE at output 20, write table[0]=0xDEADBEEF. Expect the remaining preamble unchanged; the same write in IDLE changes the next burst's sample 0 to 0xDEADBEEF.
- Back-to-back bursts: two 1-sample bursts (0x11 tlast, 0x22 tlast) presented continuously. Expect 160+1+160+1 outputs, each payload preceded by a full preamble, and exactly 1 idle cycle between bursts.
- Reset mid-preamble: assert reset for 1 cycle at output 50. Expect o_samples_tvalid=0 and o_active=0 the next cycle, and all table entries reading 0 on the next burst.
- Latency: input tvalid rises at cycle T in IDLE with tready held at 1. Expect o_samples_tvalid=1 at T+1 and the first payload sample at T+161.
